// File: rtl/regfile_read_bank_pkg.sv
// Shared CPU datapath types used by the register-file read bank and its
// read-select muxes.
package regfile_read_bank_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  localparam regbits_t REG_ZERO = 5'd0;

endpackage : regfile_read_bank_pkg

// File: rtl/regfile_read_bank_if.sv
// Write-enable / read-port bundle between the write-select decoder side
// (master) and the register-file read bank (slave).
interface regfile_read_bank_if
  import regfile_read_bank_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int DWIDTH = 32
) ();

  logic [NREGS-1:0]  en;
  logic [DWIDTH-1:0] wdat;
  regbits_t          rsel1;
  regbits_t          rsel2;
  logic [DWIDTH-1:0] rdat1;
  logic [DWIDTH-1:0] rdat2;
  logic              onehot_err;

  modport master (
    output en, wdat, rsel1, rsel2,
    input  rdat1, rdat2, onehot_err
  );

  modport slave (
    input  en, wdat, rsel1, rsel2,
    output rdat1, rdat2, onehot_err
  );

endinterface : regfile_read_bank_if

// File: rtl/regfile_read_mux.sv
// One read port: register select with write-through bypass; register 0 and
// indices beyond the implemented register count always read zero.
module regfile_read_mux
  import regfile_read_bank_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int DWIDTH = 32
) (
  input  regbits_t                      rsel,
  input  logic [NREGS-1:0]              en,
  input  logic [DWIDTH-1:0]             wdat,
  input  logic [NREGS-1:0][DWIDTH-1:0]  regs,
  output logic [DWIDTH-1:0]             rdat
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [IW-1:0] idx_s;
  logic          in_range_s;

  // Select the addressed register, preferring the word being written this cycle.
  always_comb begin
    idx_s      = rsel[IW-1:0];
    in_range_s = (32'(rsel) < 32'(NREGS));
    rdat       = '0;
    if (rsel == REG_ZERO) begin
      rdat = '0;
    end else if (!in_range_s) begin
      rdat = '0;
    end else if (en[idx_s]) begin
      rdat = wdat;
    end else begin
      rdat = regs[idx_s];
    end
  end

endmodule : regfile_read_mux

// File: rtl/regfile_read_bank.sv
// Register storage with two bypassed read ports, optional output registers
// and a one-cycle flag for multi-hot write enables.
module regfile_read_bank
  import regfile_read_bank_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int DWIDTH  = 32,
  parameter int REG_OUT = 0
) (
  input  logic                CLK,
  input  logic                RST,
  regfile_read_bank_if.slave  bus
);

  logic [NREGS-1:0][DWIDTH-1:0] regs_r;
  logic [NREGS-1:0]             en_masked_s;
  logic                         multi_hot_s;
  logic                         err_r;
  logic [DWIDTH-1:0]            rd1_s;
  logic [DWIDTH-1:0]            rd2_s;

  // Bit 0 never writes, so it is excluded from the multi-hot test.
  always_comb begin
    en_masked_s = bus.en & ~NREGS'(1);
    multi_hot_s = |(en_masked_s & (en_masked_s - NREGS'(1)));
  end

  // Storage update and error flag; reset wins over a same-cycle write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_r <= '0;
      err_r  <= 1'b0;
    end else begin
      regs_r[0] <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (bus.en[i]) begin
          regs_r[i] <= bus.wdat;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
      err_r <= multi_hot_s;
    end
  end

  regfile_read_mux #(.NREGS(NREGS), .DWIDTH(DWIDTH)) u_mux1 (
    .rsel (bus.rsel1),
    .en   (bus.en),
    .wdat (bus.wdat),
    .regs (regs_r),
    .rdat (rd1_s)
  );

  regfile_read_mux #(.NREGS(NREGS), .DWIDTH(DWIDTH)) u_mux2 (
    .rsel (bus.rsel2),
    .en   (bus.en),
    .wdat (bus.wdat),
    .regs (regs_r),
    .rdat (rd2_s)
  );

  if (REG_OUT != 0) begin : g_reg_out
    logic [DWIDTH-1:0] rdat1_r;
    logic [DWIDTH-1:0] rdat2_r;

    // Capture the bypassed read value so it appears one cycle after rsel.
    always_ff @(posedge CLK) begin
      if (RST) begin
        rdat1_r <= '0;
        rdat2_r <= '0;
      end else begin
        rdat1_r <= rd1_s;
        rdat2_r <= rd2_s;
      end
    end

    assign bus.rdat1 = rdat1_r;
    assign bus.rdat2 = rdat2_r;
  end else begin : g_comb_out
    assign bus.rdat1 = rd1_s;
    assign bus.rdat2 = rd2_s;
  end

  assign bus.onehot_err = err_r;

endmodule : regfile_read_bank

// File: doc/regfile_read_bank.md
Name: regfile_read_bank

Overview:
- 32x32-bit register storage plus its read side. This block is the reader counterpart of the write-select decoder.
- Consumes the decoder's one-hot write-enable vector and the write data, and serves two independent read ports.
- Read ports have write-through bypass and optionally registered outputs.
- Sits in the datapath between the write-select decoder and the ALU operand inputs.

Parameters:
- NREGS, 32, number of architectural registers (must equal width of en).
- DWIDTH, 32, register data width.
- REG_OUT, 0, 0 = combinational read data; 1 = read data registered (1-cycle latency).

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- en  input  NREGS  one-hot write enables from decoder; bit 0 ignored.
- wdat  input  DWIDTH  write data, applied to every register whose en bit is set.
- rsel1  input  5  read select, port 1.
- rsel2  input  5  read select, port 2.
- rdat1  output  DWIDTH  read data, port 1.
- rdat2  output  DWIDTH  read data, port 2.
- onehot_err  output  1  registered flag: previous cycle's en had more than one bit set (ignoring bit 0).

Behaviour:
- Reset:
  - RST high at a rising edge clears all registers to 0.
  - It also clears the rdat output registers (REG_OUT=1) and onehot_err.
  - RST has priority over any write in the same cycle.
  - Reset mid-stream discards that cycle's write; outputs read 0 in the next cycle.
- Register 0:
  - Hardwired 0; never written even if en[0]=1.
  - Reads of rsel=0 return 0 regardless of bypass.
- Write:
  - At each rising edge with RST low, reg[i] <= wdat for every i in 1..31 with en[i]=1.
  - en = 0 means no write.
  - Multiple set bits write all selected registers (defined behaviour, not X), and onehot_err <= 1 for one cycle.
  - Otherwise onehot_err <= 0.
- Read, REG_OUT=0:
  - rdatN = (rselN==0) ? 0 : (en[rselN] ? wdat : reg[rselN]).
  - Bypass makes a same-cycle write visible combinationally.
  - Latency 0.
- Read, REG_OUT=1:
  - rdatN registered at each edge with the same bypassed value, so data appears the cycle after rsel is presented.
  - Under RST the output registers load 0.
- Simultaneous events:
  - Both ports may select the same register; both get identical data.
  - A read and a write to the same register in the same cycle return the new wdat (both modes).
- Width rules:
  - rsel is 5 bits, so no out-of-range index exists for NREGS=32.
  - For a smaller NREGS, indices >= NREGS read 0.
- No handshake: reads are always valid; writes are accepted every cycle.

Decomposition:
- Shared package (the existing CPU types package) holds:
  - regbits_t (5-bit select)
  - word_t (32-bit)
  - the REG_ZERO = 0 constant
- One natural sub-module: regfile_read_mux.
  - Pure combinational bypass + select.
  - Instantiated twice, once per port.
  - The top owns the storage array, the optional output registers and onehot_err.

Test Plan:
- Reset then read: RST=1 for 2 cycles, then rsel1=5, rsel2=31 -> rdat1=0, rdat2=0, onehot_err=0.
- Write then read: en=32'h0000_0020, wdat=32'hDEAD_BEEF, then next cycle rsel1=5 -> rdat1=32'hDEADBEEF (REG_OUT=1: one cycle later).
- Bypass: en=32'h0000_0400, wdat=32'h1234_5678, rsel2=10 in the same cycle -> rdat2=32'h12345678 in that cycle (REG_OUT=0) or on the next edge (REG_OUT=1).
- Zero register: en=32'h0000_0001, wdat=32'hFFFF_FFFF, rsel1=0 during and after -> rdat1=0 always, onehot_err=0.
- Multi-hot: en=32'h0000_0006, wdat=32'hA5A5_A5A5 -> onehot_err=1 for exactly one cycle; reg1 and reg2 both read A5A5A5A5.
- Reset mid-write: en=32'h0000_0100, wdat=7, RST=1 same cycle -> rsel1=8 next cycle reads 0.
